// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised Genius memory-game controller.
// Plays back the stored sequence on leds, checks the player's repeats on
// botoes, then records one new move per round until MAX_RODADAS is reached.
// Optional feature macro: TIMEOUT_EN (per-press timeout -> FIM_TIMEOUT).
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int MAX_RODADAS    = 16,
  parameter int TEMPO_LED      = 1000,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int JOGADA_INICIAL = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               iniciar,
  input  logic [N_BOTOES-1:0]                botoes,
  output logic [N_BOTOES-1:0]                leds,
  output logic                               pronto,
  output logic                               ganhou,
  output logic                               perdeu,
  output logic                               db_timeout,
  output logic [$clog2(MAX_RODADAS+1)-1:0]   db_rodada,
  output logic [$clog2(MAX_RODADAS)-1:0]     db_contagem,
  output logic [4:0]                         db_estado
);

  localparam int RW   = $clog2(MAX_RODADAS + 1);
  localparam int AW   = $clog2(MAX_RODADAS);
  localparam int TMAX = (TIMEOUT_CICLOS > TEMPO_LED) ? TIMEOUT_CICLOS : TEMPO_LED;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [4:0] INICIAL        = 5'h00;
  localparam logic [4:0] PREPARA        = 5'h01;
  localparam logic [4:0] MOSTRA         = 5'h02;
  localparam logic [4:0] INTERVALO      = 5'h03;
  localparam logic [4:0] ESPERA_JOGADA  = 5'h04;
  localparam logic [4:0] REGISTRA       = 5'h05;
  localparam logic [4:0] COMPARA        = 5'h06;
  localparam logic [4:0] PROXIMA_JOGADA = 5'h07;
  localparam logic [4:0] ESPERA_NOVA    = 5'h08;
  localparam logic [4:0] GRAVA_NOVA     = 5'h09;
  localparam logic [4:0] PROXIMA_RODADA = 5'h0A;
  localparam logic [4:0] FIM_GANHOU     = 5'h0B;
  localparam logic [4:0] FIM_PERDEU     = 5'h0E;
  localparam logic [4:0] FIM_TIMEOUT    = 5'h0F;

  logic [4:0]          estado, prox;
  logic [RW-1:0]       rodada;
  logic [AW-1:0]       addr;
  logic [TW-1:0]       tmr;
  logic [N_BOTOES-1:0] botoes_q;
  logic [N_BOTOES-1:0] jogada;
  logic [N_BOTOES-1:0] mem [MAX_RODADAS];

  logic press, ultima, acerto, fim_led, esgotou;

  // A press is the first cycle botoes leaves all-zero; held buttons never re-trigger.
  assign press   = (|botoes) && !(|botoes_q);
  assign ultima  = (RW'(addr) == rodada - RW'(1));
  assign acerto  = (jogada == mem[addr]);
  assign fim_led = (tmr == TW'(TEMPO_LED - 1));
`ifdef TIMEOUT_EN
  assign esgotou = (tmr == TW'(TIMEOUT_CICLOS - 1));
`else
  assign esgotou = 1'b0;
`endif

  // Next-state logic; a press on the final timeout cycle takes priority.
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
        if (iniciar) prox = PREPARA;
      PREPARA:        prox = MOSTRA;
      MOSTRA:         if (fim_led) prox = INTERVALO;
      INTERVALO:      if (fim_led) prox = ultima ? ESPERA_JOGADA : MOSTRA;
      ESPERA_JOGADA:
        if (press)        prox = REGISTRA;
        else if (esgotou) prox = FIM_TIMEOUT;
      REGISTRA:       prox = COMPARA;
      COMPARA:
        if (!acerto)                          prox = FIM_PERDEU;
        else if (!ultima)                     prox = PROXIMA_JOGADA;
        else if (rodada == RW'(MAX_RODADAS))  prox = FIM_GANHOU;
        else                                  prox = ESPERA_NOVA;
      PROXIMA_JOGADA: prox = ESPERA_JOGADA;
      ESPERA_NOVA:
        if (press)        prox = GRAVA_NOVA;
        else if (esgotou) prox = FIM_TIMEOUT;
      GRAVA_NOVA:     prox = PROXIMA_RODADA;
      PROXIMA_RODADA: prox = MOSTRA;
      default:        prox = INICIAL;
    endcase
  end

  // Control registers: state, shared cycle timer (cleared on every state change), counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      tmr      <= '0;
      rodada   <= '0;
      addr     <= '0;
      botoes_q <= '0;
    end else begin
      estado   <= prox;
      botoes_q <= botoes;
      tmr      <= (prox != estado) ? '0 : tmr + TW'(1);
      case (estado)
        PREPARA: begin
          rodada <= RW'(1);
          addr   <= '0;
        end
        INTERVALO:
          if (fim_led) addr <= ultima ? '0 : addr + AW'(1);
        PROXIMA_JOGADA:
          addr <= addr + AW'(1);
        PROXIMA_RODADA: begin
          rodada <= rodada + RW'(1);
          addr   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Move latch and sequence memory; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if ((estado == ESPERA_JOGADA || estado == ESPERA_NOVA) && press)
      jogada <= botoes;
    if (estado == PREPARA)
      mem[0] <= N_BOTOES'(JOGADA_INICIAL);
    else if (estado == GRAVA_NOVA)
      mem[rodada[AW-1:0]] <= jogada;
  end

  assign leds        = (estado == MOSTRA) ? mem[addr] : '0;
  assign pronto      = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign ganhou      = (estado == FIM_GANHOU);
  assign perdeu      = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
`ifdef TIMEOUT_EN
  assign db_timeout  = (estado == FIM_TIMEOUT);
`else
  assign db_timeout  = 1'b0;
`endif
  assign db_rodada   = rodada;
  assign db_contagem = addr;
  assign db_estado   = estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param: scoreboard bench for the memory-game controller.
// Expected playback moves are queued when the stimulus that triggers a
// playback is driven; a monitor pops and compares each lit move on leds.
module tb_jogo_memoria_param;
  localparam int NB = 4, MR = 4, TL = 10, TO = 100;

  logic        clock = 1'b0;
  logic        reset, iniciar;
  logic [3:0]  botoes;
  logic [3:0]  leds;
  logic        pronto, ganhou, perdeu, db_timeout;
  logic [2:0]  db_rodada;
  logic [1:0]  db_contagem;
  logic [4:0]  db_estado;

  jogo_memoria_param #(.N_BOTOES(NB), .MAX_RODADAS(MR), .TEMPO_LED(TL),
                       .TIMEOUT_CICLOS(TO), .JOGADA_INICIAL(1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_estado(db_estado));

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] seq [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_state(input logic [4:0] code, input int budget, input string tag);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      tick();
      n++;
    end
    chk(tag, db_estado, code);
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    tick();
    botoes = 4'b0000;
    tick();
  endtask

  task automatic start_game();
    exp_q.push_back(4'b0001);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Monitor: each lit move is popped from the scoreboard and its duration checked.
  initial begin
    int run = 0;
    logic [3:0] e;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        run = 0;
      end else if (leds != 4'b0000) begin
        if (run == 0) begin
          if (exp_q.size() == 0) chk("led_unexpected", leds, 0);
          else begin
            e = exp_q.pop_front();
            chk("led_move", leds, e);
          end
        end
        run++;
      end else if (run != 0) begin
        chk("led_len", run, TL);
        run = 0;
      end
    end
  end

  initial begin
    reset = 1'b0; iniciar = 1'b0; botoes = 4'b0000;
    tick();
    // Reset state
    chk("rst_estado", db_estado, 5'h00);
    chk("rst_leds", leds, 0);
    chk("rst_flags", {pronto, ganhou, perdeu, db_timeout}, 4'b0000);
    chk("rst_cnt", {db_rodada, db_contagem}, 0);
    reset = 1'b1;
    tick();
    chk("idle_estado", db_estado, 5'h00);

    // Full winning game
    start_game();
    for (int r = 1; r <= MR; r++) begin
      wait_state(5'h04, 300, "wait_espera");
      chk("queue_drained", exp_q.size(), 0);
      chk("rodada", db_rodada, r);
      for (int i = 0; i < r; i++) begin
        press(seq[i]);
        if (i < r - 1) wait_state(5'h04, 10, "wait_next");
      end
      if (r < MR) begin
        wait_state(5'h08, 10, "wait_nova");
        for (int i = 0; i <= r; i++) exp_q.push_back(seq[i]);
        press(seq[r]);
      end else begin
        wait_state(5'h0B, 10, "wait_ganhou");
        chk("win_flags", {pronto, ganhou, perdeu}, 3'b110);
      end
    end

    // Wrong move in round 2, exact latency
    start_game();
    wait_state(5'h04, 100, "r1_espera");
    press(4'b0001);
    wait_state(5'h08, 10, "r1_nova");
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
    press(4'b0100);
    wait_state(5'h04, 100, "r2_espera");
    press(4'b0001);
    wait_state(5'h04, 10, "r2_move2");
    botoes = 4'b0010;
    tick();
    chk("lat_e1", db_estado, 5'h05);
    botoes = 4'b0000;
    tick();
    chk("lat_e2", {db_estado, perdeu}, {5'h06, 1'b0});
    tick();
    chk("lat_e3", {db_estado, perdeu, ganhou, pronto}, {5'h0E, 3'b101});

    // Multi-button press loses, then restart
    start_game();
    wait_state(5'h04, 100, "restart_espera");
    chk("restart_rodada", db_rodada, 1);
    press(4'b0011);
    wait_state(5'h0E, 5, "multi_perdeu");
    chk("multi_flags", {perdeu, ganhou}, 2'b10);

    // Timeout (or indefinite wait without the feature)
    start_game();
    wait_state(5'h04, 100, "to_espera");
`ifdef TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("to_before", db_estado, 5'h04);
    tick();
    chk("to_after", {db_estado, db_timeout, perdeu, pronto}, {5'h0F, 3'b111});
    start_game();
    wait_state(5'h04, 100, "to_restart");
`else
    repeat (TO + 50) tick();
    chk("no_to", {db_estado, db_timeout}, {5'h04, 1'b0});
`endif

    // Held button counted once; async reset during round-3 playback
    press(4'b0001);
    wait_state(5'h08, 10, "h_nova1");
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
    press(4'b0100);
    wait_state(5'h04, 100, "h_espera2");
    botoes = 4'b0001;
    repeat (8) tick();
    chk("held_once", {db_estado, db_contagem}, {5'h04, 2'd1});
    botoes = 4'b0000;
    tick();
    press(4'b0100);
    wait_state(5'h08, 10, "h_nova2");
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    press(4'b0010);
    wait_state(5'h02, 10, "r3_mostra");
    chk("r3_rodada", db_rodada, 3);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {db_estado, leds}, {5'h00, 4'b0000});
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_cnt", {db_rodada, db_contagem}, 0);
    start_game();
    wait_state(5'h04, 100, "post_rst_espera");
    chk("post_rst_rodada", db_rodada, 1);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
